ssd_scan_decoder: RTL

SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

---
 rtl/puvvada_says_pkg.sv | 21 ++
 rtl/ssd_seg_decode.sv | 30 +++
 rtl/ssd_scan_decoder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/puvvada_says_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment
// patterns {Ca..Cg} for the ten digits, the blank pattern and its code.
package puvvada_says_pkg;

    localparam int unsigned DEFAULT_N_DIGITS = 6;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [6:0] BLANK_PATTERN = 7'b1111111;
    localparam logic [3:0] BLANK_CODE    = 4'hF;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational decode of an active-low {Ca..Cg} segment pattern into a digit
// value; legal_o is low for any pattern that is neither a digit nor blank.
module ssd_seg_decode
    import puvvada_says_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] value_o,
    output logic       legal_o
);

    always_comb begin
        value_o = 4'h0;
        legal_o = 1'b1;
        case (pattern_i)
            SEG_0:         value_o = 4'd0;
            SEG_1:         value_o = 4'd1;
            SEG_2:         value_o = 4'd2;
            SEG_3:         value_o = 4'd3;
            SEG_4:         value_o = 4'd4;
            SEG_5:         value_o = 4'd5;
            SEG_6:         value_o = 4'd6;
            SEG_7:         value_o = 4'd7;
            SEG_8:         value_o = 4'd8;
            SEG_9:         value_o = 4'd9;
            BLANK_PATTERN: value_o = BLANK_CODE;
            default:       legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Recovers digit values from a multiplexed seven-segment anode/cathode scan.
// Optional decimal-point capture is enabled with macro SSD_DP_CAPTURE_EN.
module ssd_scan_decoder
    import puvvada_says_pkg::*;
#(
    parameter int unsigned N_DIGITS   = DEFAULT_N_DIGITS,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [7:0]            An,
    input  logic [7:0]            Cath,
    output logic [4*N_DIGITS-1:0] Digits,
    output logic [N_DIGITS-1:0]   Valid,
    output logic [N_DIGITS-1:0]   Dp_flags,
    output logic                  Frame_done,
    output logic                  Bad_pattern,
    output logic                  Multi_an_err
);

    localparam logic [7:0]          CNT_MAX  = 8'(STABLE_CNT - 1);
    localparam logic [N_DIGITS-1:0] ALL_SEEN = '1;

    // Key is what must stay constant for the hold counter to advance.
`ifdef SSD_DP_CAPTURE_EN
    localparam int unsigned KEY_W = 8;
    logic [KEY_W-1:0] key;
    assign key = Cath;
`else
    localparam int unsigned KEY_W = 7;
    logic [KEY_W-1:0] key;
    logic             unused_dp;
    assign key       = Cath[7:1];
    assign unused_dp = Cath[0];
`endif

    logic [3:0]            low_cnt;
    logic [2:0]            act_idx;
    logic                  upper_ok;
    logic                  active;
    logic                  multi;

    logic [3:0]            seg_value;
    logic                  seg_legal;
    logic                  capture;
    logic [N_DIGITS-1:0]   seen_new;

    logic                  active_q;
    logic [2:0]            idx_q;
    logic [KEY_W-1:0]      key_q;
    logic [7:0]            cnt_q, cnt_d;
    logic                  multi_q;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic                  frame_q, frame_d;
    logic                  bad_q, bad_d;
    logic                  merr_q, merr_d;

    ssd_seg_decode u_seg_decode (
        .pattern_i (Cath[7:1]),
        .value_o   (seg_value),
        .legal_o   (seg_legal)
    );

    // A digit is selected only by a single low anode inside the decoded range.
    always_comb begin
        low_cnt  = 4'd0;
        act_idx  = 3'd0;
        upper_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!An[i]) begin
                low_cnt = low_cnt + 4'd1;
                act_idx = 3'(i);
                if (i >= int'(N_DIGITS)) upper_ok = 1'b0;
            end
        end
        active = (low_cnt == 4'd1) && upper_ok;
        multi  = (low_cnt > 4'd1);
    end

    always_comb begin
        cnt_d    = 8'd0;
        capture  = 1'b0;
        digits_d = digits_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        seen_new = seen_q;
        frame_d  = 1'b0;
        bad_d    = 1'b0;
        merr_d   = multi & ~multi_q;

        if (active && active_q && (act_idx == idx_q) && (key == key_q)) begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
            capture = (cnt_q == CNT_MAX - 8'd1);
        end

        if (capture) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                if (act_idx == 3'(i)) begin
                    seen_new[i] = 1'b1;
                    valid_d[i]  = seg_legal;
                    if (seg_legal) digits_d[4*i +: 4] = seg_value;
                end
            end
            bad_d = ~seg_legal;
            if (seen_new == ALL_SEEN) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_new;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            active_q <= 1'b0;
            idx_q    <= 3'd0;
            key_q    <= '0;
            cnt_q    <= 8'd0;
            multi_q  <= 1'b0;
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            bad_q    <= 1'b0;
            merr_q   <= 1'b0;
        end else begin
            active_q <= active;
            idx_q    <= act_idx;
            key_q    <= key;
            cnt_q    <= cnt_d;
            multi_q  <= multi;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            bad_q    <= bad_d;
            merr_q   <= merr_d;
        end
    end

`ifdef SSD_DP_CAPTURE_EN
    logic [N_DIGITS-1:0] dp_q, dp_d;

    always_comb begin
        dp_d = dp_q;
        if (capture) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                if (act_idx == 3'(i)) dp_d[i] = ~Cath[0];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) dp_q <= '0;
        else        dp_q <= dp_d;
    end

    assign Dp_flags = dp_q;
`else
    assign Dp_flags = '0;
`endif

    assign Digits       = digits_q;
    assign Valid        = valid_q;
    assign Frame_done   = frame_q;
    assign Bad_pattern  = bad_q;
    assign Multi_an_err = merr_q;

endmodule
